seq_addsub: RTL and testbench

- Parametrised, multi-cycle two's-complement adder/subtractor. It is the successor to the fixed 64-bit ripple add/sub in the Execute-stage ALU.
- Processes CHUNK bits per cycle and holds the inter-chunk carry in a register. This trades latency for a short critical path.
- Adds a valid/ready handshake and full condition flags (carry, overflow, zero, sign) for the condition-code logic.

---
 rtl/seq_addsub_pkg.sv | 18 +
 rtl/seq_addsub_chunk.sv | 24 ++
 rtl/seq_addsub.sv | 129 ++++++++++++
 tb/tb_seq_addsub.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the sequential adder/subtractor.
// Build option: SEQ_ADDSUB_SAT_EN clamps the result on signed overflow.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit chunk_fits(int w, int c);
    return (c >= 1) && (c <= w) && ((w % c) == 0);
  endfunction

endpackage

// File: rtl/seq_addsub_chunk.sv
// Combinational CHUNK-bit adder slice, reused once per chunk.
// Reports carry out and carry into its top bit.
module addsub_chunk
  import seq_addsub_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] t;

  assign t    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s    = t[CHUNK-1:0];
  assign cout = t[CHUNK];
  // top-bit sum = a ^ b ^ carry_in, so the carry in falls out directly
  assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/sub, CHUNK bits per cycle, with handshake and flags.
// Build option: SEQ_ADDSUB_SAT_EN saturates sum on signed overflow.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             sign
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_addsub: WIDTH must be a multiple of CHUNK");
  end

  state_t state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bx_r;
  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-1:0] sum_fin;
  logic [CW-1:0] cnt;
  logic carry;
  logic [31:0] base;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic cco;
  logic ccm;

  assign base = 32'(cnt) * CHUNK;
  assign ca   = a_r[base +: CHUNK];
  assign cb   = bx_r[base +: CHUNK];

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (ca),
    .b   (cb),
    .cin (carry),
    .s   (cs),
    .cout(cco),
    .cmsb(ccm)
  );

  always_comb begin
    sum_nx = sum;
    sum_nx[base +: CHUNK] = cs;
  end

`ifdef SEQ_ADDSUB_SAT_EN
  always_comb begin
    sum_fin = sum_nx;
    if (ccm ^ cco)
      sum_fin = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_fin = sum_nx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      bx_r      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            bx_r     <= (sub == OP_SUB) ? ~b : b;
            carry    <= (sub == OP_SUB);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          carry <= cco;
          if (cnt == LAST) begin
            sum       <= sum_fin;
            c_out     <= cco;
            overflow  <= ccm ^ cco;
            zero      <= (sum_fin == '0);
            sign      <= sum_nx[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sum <= sum_nx;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed self-checking bench for seq_addsub (64-bit, 16-bit chunks).
// Expected sums follow SEQ_ADDSUB_SAT_EN when the bench is built with it.
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        c_out;
  logic        overflow;
  logic        zero;
  logic        sign;

  int compared = 0;
  int mismatched = 0;

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(64), .CHUNK(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero),
    .sign     (sign)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [63:0] av,
                       input logic [63:0] bv, input logic sv,
                       input logic [63:0] es, input logic ec,
                       input logic eo, input logic ez, input logic esg);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    a = av;
    b = bv;
    sub = sv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    sub = ~sv;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd5);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".c_out"}, 64'(c_out), 64'(ec));
    chk({tag, ".overflow"}, 64'(overflow), 64'(eo));
    chk({tag, ".zero"}, 64'(zero), 64'(ez));
    chk({tag, ".sign"}, 64'(sign), 64'(esg));
    chk({tag, ".busy_ready"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".zero_hold"}, 64'(zero), 64'(ez));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    step();
    step();
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum", sum, 64'd0);
    chk("rst.flags", {60'd0, c_out, overflow, zero, sign}, 64'd0);
    reset = 1'b0;
    step();

    do_op("add5_3", 64'd5, 64'd3, 1'b0, 64'd8, 0, 0, 0, 0);
    do_op("sub3_3", 64'd3, 64'd3, 1'b1, 64'd0, 1, 0, 1, 0);
    do_op("sub3_5", 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1);
`ifdef SEQ_ADDSUB_SAT_EN
    do_op("ovf_pos", MAXP, 64'd1, 1'b0, MAXP, 0, 1, 0, 1);
    do_op("ovf_neg", MINN, 64'd1, 1'b1, MINN, 1, 1, 0, 0);
`else
    do_op("ovf_pos", MAXP, 64'd1, 1'b0, MINN, 0, 1, 0, 1);
    do_op("ovf_neg", MINN, 64'd1, 1'b1, MAXP, 1, 1, 0, 0);
`endif
    do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1, 0, 1, 0);

    a = 64'd10;
    b = 64'd20;
    sub = 1'b0;
    in_valid = 1'b1;
    step();
    a = 64'd7;
    b = 64'd2;
    sub = 1'b1;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp.latency", 64'(n), 64'd5);
    for (int i = 0; i < 10; i++) begin
      chk("bp.valid_hold", 64'(out_valid), 64'd1);
      chk("bp.sum_hold", sum, 64'd30);
      chk("bp.ready_low", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.valid_drop", 64'(out_valid), 64'd0);
    chk("bp.reaccept_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp.accepted", 64'(in_ready), 64'd0);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp2.latency", 64'(n), 64'd5);
    chk("bp2.sum", sum, 64'd5);
    chk("bp2.c_out", 64'(c_out), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    a = 64'h1234;
    b = 64'd1;
    sub = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.sum", sum, 64'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("abort.no_result", 64'(n), 64'd0);
    do_op("post_rst", 64'd1, 64'd1, 1'b0, 64'd2, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
